// File: rtl/jpeg_dc_dpcm_encoder.sv
// jpeg_dc_dpcm_encoder
// Baseline JPEG DC coefficient encoder: per-component DPCM prediction,
// magnitude categorisation, luma/chroma DC Huffman lookup and merge of the
// Huffman code with the extra bits into one right-aligned code word.
//
// Optional feature: define JPEG_DC_RESTART_EN to add a 'restart' pulse input
// that clears all predictors exactly like frame_start (RSTn marker boundary).
//
// Pipeline: accept (diff formed combinationally, predictor updated)
//   -> s1 register (diff, comp) -> categorise + lookup -> s2 register (output).
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. Producers never drop valid or change data before the transfer; ready
// is a function of registered pipeline occupancy and out_ready only (never of
// in_valid). Each stage advances when the stage after it is empty or advancing.
module jpeg_dc_dpcm_encoder #(
  parameter int COEF_W   = 11,
  parameter int NUM_COMP = 3,
  parameter int CIDX_W   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     frame_start,
`ifdef JPEG_DC_RESTART_EN
  input  logic                     restart,
`endif
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [COEF_W-1:0] in_dc,
  input  logic [CIDX_W-1:0]        in_comp,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_code,
  output logic [5:0]               out_len,
  output logic [CIDX_W-1:0]        out_comp,
  output logic                     err_comp
);

  localparam int DW    = COEF_W + 1;
  localparam int NPRED = 1 << CIDX_W;
  localparam logic [CIDX_W:0] NUM_COMP_L = (CIDX_W + 1)'(NUM_COMP);

  // Huffman DC tables, returned as {length[3:0], code[10:0]} right-aligned.
  function automatic logic [14:0] huff(input logic chroma, input logic [3:0] c);
    logic [14:0] r;
    r = {4'd2, 11'd0};
    if (!chroma) begin
      case (c)
        4'd0:    r = {4'd2, 11'd0};
        4'd1:    r = {4'd3, 11'd2};
        4'd2:    r = {4'd3, 11'd3};
        4'd3:    r = {4'd3, 11'd4};
        4'd4:    r = {4'd3, 11'd5};
        4'd5:    r = {4'd3, 11'd6};
        4'd6:    r = {4'd4, 11'd14};
        4'd7:    r = {4'd5, 11'd30};
        4'd8:    r = {4'd6, 11'd62};
        4'd9:    r = {4'd7, 11'd126};
        4'd10:   r = {4'd8, 11'd254};
        4'd11:   r = {4'd9, 11'd510};
        default: r = {4'd2, 11'd0};
      endcase
    end else begin
      case (c)
        4'd0:    r = {4'd2, 11'd0};
        4'd1:    r = {4'd2, 11'd1};
        4'd2:    r = {4'd2, 11'd2};
        4'd3:    r = {4'd3, 11'd6};
        4'd4:    r = {4'd4, 11'd14};
        4'd5:    r = {4'd5, 11'd30};
        4'd6:    r = {4'd6, 11'd62};
        4'd7:    r = {4'd7, 11'd126};
        4'd8:    r = {4'd8, 11'd254};
        4'd9:    r = {4'd9, 11'd510};
        4'd10:   r = {4'd10, 11'd1022};
        4'd11:   r = {4'd11, 11'd2046};
        default: r = {4'd2, 11'd0};
      endcase
    end
    return r;
  endfunction

  logic signed [COEF_W-1:0] pred [NPRED];
  logic                     s1_valid;
  logic [DW-1:0]            s1_diff;
  logic [CIDX_W-1:0]        s1_comp;
  logic                     s2_valid;
  logic [31:0]              s2_code;
  logic [5:0]               s2_len;
  logic [CIDX_W-1:0]        s2_comp;
  logic                     err_q;

  logic                     clear_pred;
  logic                     accept;
  logic                     comp_ok;
  logic                     s2_ready;
  logic                     s1_adv;
  logic [COEF_W-1:0]        pred_sel;
  logic [DW-1:0]            diff0;

`ifdef JPEG_DC_RESTART_EN
  assign clear_pred = frame_start | restart;
`else
  assign clear_pred = frame_start;
`endif

  assign s2_ready = !s2_valid || out_ready;
  assign s1_adv   = s1_valid && s2_ready;
  assign in_ready = !s1_valid || s2_ready;
  assign accept   = in_valid && in_ready;
  assign comp_ok  = ({1'b0, in_comp} < NUM_COMP_L);

  // Stage 0: pick the predictor (zero on clear or invalid component), form diff.
  always_comb begin
    pred_sel = '0;
    if (!clear_pred && comp_ok) pred_sel = pred[in_comp];
    diff0 = {in_dc[COEF_W-1], in_dc} - {pred_sel[COEF_W-1], pred_sel};
  end

  // Predictor bank: clear on frame boundary, then load the accepted sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NPRED; i++) pred[i] <= '0;
    end else begin
      if (clear_pred) begin
        for (int i = 0; i < NPRED; i++) pred[i] <= '0;
      end
      if (accept && comp_ok) pred[in_comp] <= in_dc;
    end
  end

  // Stage 1 register: difference and component index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_diff  <= '0;
      s1_comp  <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_diff  <= diff0;
      s1_comp  <= in_comp;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  logic [DW-1:0] mag;
  logic [DW-1:0] ones;
  logic [3:0]    cat;
  logic [31:0]   mask;
  logic [31:0]   extra;
  logic [14:0]   hent;
  logic [31:0]   code1;
  logic [5:0]    len1;

  // Categorise, take one's-complement extra bits, look up and merge.
  always_comb begin
    mag  = s1_diff[DW-1] ? (~s1_diff + 1'b1) : s1_diff;
    ones = s1_diff[DW-1] ? (s1_diff - 1'b1) : s1_diff;
    cat  = '0;
    for (int i = 0; i < DW; i++) begin
      if (mag[i]) cat = 4'(i + 1);
    end
    mask  = (32'd1 << cat) - 32'd1;
    extra = {{(32 - DW){1'b0}}, ones} & mask;
    hent  = huff(s1_comp != '0, cat);
    code1 = ({21'd0, hent[10:0]} << cat) | extra;
    len1  = {2'b00, hent[14:11]} + {2'b00, cat};
  end

  // Stage 2 register: merged code word presented to the packer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_code  <= '0;
      s2_len   <= '0;
      s2_comp  <= '0;
    end else if (s1_adv) begin
      s2_valid <= 1'b1;
      s2_code  <= code1;
      s2_len   <= len1;
      s2_comp  <= s1_comp;
    end else if (out_ready) begin
      s2_valid <= 1'b0;
    end
  end

  // Sticky error: an out-of-range component index was accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else if (accept && !comp_ok) err_q <= 1'b1;
  end

  assign out_valid = s2_valid;
  assign out_code  = s2_code;
  assign out_len   = s2_len;
  assign out_comp  = s2_comp;
  assign err_comp  = err_q;

endmodule

// File: tb/tb_jpeg_dc_dpcm_encoder.sv
// tb_jpeg_dc_dpcm_encoder
// Directed bench: table of single-sample vectors with hand-computed merged
// codes, then a stalled stream through the scoreboard and a mid-flight reset.
module tb_jpeg_dc_dpcm_encoder;

  localparam int COEF_W = 11;
  localparam int CIDX_W = 2;
  localparam int OW     = 32 + 6 + CIDX_W;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                     frame_start = 1'b0;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic signed [COEF_W-1:0] in_dc = '0;
  logic [CIDX_W-1:0]        in_comp = '0;
  logic                     out_valid;
  logic                     out_ready = 1'b1;
  logic [31:0]              out_code;
  logic [5:0]               out_len;
  logic [CIDX_W-1:0]        out_comp;
  logic                     err_comp;

  jpeg_dc_dpcm_encoder #(.COEF_W(COEF_W), .NUM_COMP(3), .CIDX_W(CIDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
`ifdef JPEG_DC_RESTART_EN
    .restart(1'b0),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .in_dc(in_dc), .in_comp(in_comp),
    .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
    .out_len(out_len), .out_comp(out_comp), .err_comp(err_comp)
  );

  int checks = 0;
  int errors = 0;
  logic [OW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic              fs;
    logic [COEF_W-1:0] dc;
    logic [CIDX_W-1:0] comp;
    logic [31:0]       code;
    logic [5:0]        len;
    logic              err;
  } vec_t;

  vec_t vecs[14];

  // Stall-stream stimulus and expected merged words
  logic [COEF_W-1:0] st_dc[4];
  logic [CIDX_W-1:0] st_comp[4];

  initial begin
    int lat;
    int idx;
    int rx;
    logic [31:0] held;
    logic [OW-1:0] e;

    // Sequential vectors: predictor state carries from one row to the next.
    vecs[0]  = '{1'b1, 11'(5),     2'd0, 32'h25,     6'd6,  1'b0}; // diff 5, cat 3
    vecs[1]  = '{1'b0, 11'(5),     2'd0, 32'h0,      6'd2,  1'b0}; // diff 0
    vecs[2]  = '{1'b0, 11'(2),     2'd0, 32'h0C,     6'd5,  1'b0}; // diff -3
    vecs[3]  = '{1'b1, 11'(-1024), 2'd1, 32'h3FF3FF, 6'd22, 1'b0}; // chroma cat 11
    vecs[4]  = '{1'b0, 11'(100),   2'd0, 32'hF64,    6'd12, 1'b0}; // comp0 cleared by row 3
    vecs[5]  = '{1'b1, 11'(7),     2'd0, 32'h27,     6'd6,  1'b0}; // fs with sample: diff 7
    vecs[6]  = '{1'b0, 11'(6),     2'd3, 32'h36,     6'd6,  1'b1}; // invalid comp, chroma
    vecs[7]  = '{1'b0, 11'(4),     2'd0, 32'h0C,     6'd5,  1'b1}; // pred still 7
    vecs[8]  = '{1'b0, 11'(-1),    2'd2, 32'h2,      6'd3,  1'b1}; // diff -1
    vecs[9]  = '{1'b0, 11'(1023),  2'd1, 32'hFFBFF,  6'd20, 1'b1}; // chroma cat 10
    vecs[10] = '{1'b0, 11'(-1024), 2'd1, 32'h3FF000, 6'd22, 1'b1}; // diff -2047
    vecs[11] = '{1'b0, 11'(1),     2'd2, 32'hA,      6'd4,  1'b1}; // diff 2
    vecs[12] = '{1'b0, 11'(-1024), 2'd0, 32'hFF3FB,  6'd20, 1'b1}; // diff -1028 luma
    vecs[13] = '{1'b0, 11'(1023),  2'd0, 32'hFF7FF,  6'd20, 1'b1}; // diff +2047 luma

    // Reset state
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_code", out_code, 32'd0);
    check("rst_out_len", 32'(out_len), 32'd0);
    check("rst_out_comp", 32'(out_comp), 32'd0);
    check("rst_err_comp", 32'(err_comp), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven single samples, out_ready held high
    for (int v = 0; v < 14; v++) begin
      frame_start = vecs[v].fs;
      in_valid    = 1'b1;
      in_dc       = vecs[v].dc;
      in_comp     = vecs[v].comp;
      #1;
      check($sformatf("v%0d_in_ready", v), 32'(in_ready), 32'd1);
      @(negedge clk);
      frame_start = 1'b0;
      in_valid    = 1'b0;
      lat = 1;
      while (!out_valid && lat < 8) begin
        @(negedge clk);
        lat++;
      end
      check($sformatf("v%0d_latency", v), 32'(lat), 32'd2);
      check($sformatf("v%0d_code", v), out_code, vecs[v].code);
      check($sformatf("v%0d_len", v), 32'(out_len), 32'(vecs[v].len));
      check($sformatf("v%0d_comp", v), 32'(out_comp), 32'(vecs[v].comp));
      check($sformatf("v%0d_err", v), 32'(err_comp), 32'(vecs[v].err));
    end
    @(negedge clk);

    // Stalled stream: comps 0,1,2,0 with out_ready low in cycles 1..3
    st_dc[0] = 11'(10); st_comp[0] = 2'd0;
    st_dc[1] = 11'(20); st_comp[1] = 2'd1;
    st_dc[2] = 11'(-5); st_comp[2] = 2'd2;
    st_dc[3] = 11'(13); st_comp[3] = 2'd0;
    exp_q.push_back({32'h5A,  6'd7,  2'd0});
    exp_q.push_back({32'h3D4, 6'd10, 2'd1});
    exp_q.push_back({32'h32,  6'd6,  2'd2});
    exp_q.push_back({32'hF,   6'd5,  2'd0});
    idx = 0;
    rx = 0;
    held = '0;
    for (int c = 0; c < 40 && rx < 4; c++) begin
      if (c > 0) @(negedge clk);
      out_ready   = !(c >= 1 && c <= 3);
      in_valid    = (idx < 4);
      frame_start = (idx == 0);
      in_dc       = st_dc[idx < 4 ? idx : 3];
      in_comp     = st_comp[idx < 4 ? idx : 3];
      #1;
      if (c == 2 || c == 3) check($sformatf("stall_in_ready_c%0d", c), 32'(in_ready), 32'd0);
      if (c == 2) held = out_code;
      if (c == 3) begin
        check("stall_valid_held", 32'(out_valid), 32'd1);
        check("stall_code_held", out_code, held);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("stream_extra_output", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("stream%0d_code", rx), out_code, e[OW-1 -: 32]);
          check($sformatf("stream%0d_len", rx), 32'(out_len), 32'(e[CIDX_W +: 6]));
          check($sformatf("stream%0d_comp", rx), 32'(out_comp), 32'(e[CIDX_W-1:0]));
        end
        rx++;
      end
      if (in_valid && in_ready) idx++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    frame_start = 1'b0;
    out_ready = 1'b1;
    check("stream_count", 32'(rx), 32'd4);
    check("stream_queue_empty", 32'(exp_q.size()), 32'd0);

    // Mid-flight asynchronous reset drops the code and clears err_comp
    in_valid = 1'b1;
    in_dc    = 11'(9);
    in_comp  = 2'd0;
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_err_cleared", 32'(err_comp), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("arst_no_output", 32'(out_valid), 32'd0);
    end

    // Predictor cleared by reset: comp0 DC=9 -> diff 9, cat 4, luma 101 + 1001
    in_valid = 1'b1;
    in_dc    = 11'(9);
    in_comp  = 2'd0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_valid", 32'(out_valid), 32'd1);
    check("post_rst_code", out_code, 32'h59);
    check("post_rst_len", 32'(out_len), 32'd7);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
